// File: rtl/logic_pipe_pkg_311.sv
// logic_pipe_pkg_311: opcode encodings shared by the gate pipeline and its operator
package logic_pipe_pkg_311;
    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
    localparam logic [OP_W-1:0] OP_ACCX = 3'd7;
endpackage

// File: rtl/logic_op_311.sv
// logic_op_311: combinational bitwise gate / xor-accumulate operator
module logic_op_311
    import logic_pipe_pkg_311::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_acc,
    output logic [WIDTH-1:0] o_y
);
    // select the gate function; every opcode is defined, ACCX folds a into acc
    always_comb begin
        o_y = i_acc ^ i_a;
        case (i_op)
            OP_NOT:  o_y = ~i_a;
            OP_OR:   o_y = i_a | i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_NAND: o_y = ~(i_a & i_b);
            OP_NOR:  o_y = ~(i_a | i_b);
            OP_XOR:  o_y = i_a ^ i_b;
            OP_XNOR: o_y = ~(i_a ^ i_b);
            default: o_y = i_acc ^ i_a;
        endcase
    end
endmodule

// File: rtl/logic_pipe_311.sv
// logic_pipe_311: two-stage valid/ready gate pipeline with xor accumulator and result flags
module logic_pipe_311
    import logic_pipe_pkg_311::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_311,
    input  logic             rst_311,
    input  logic             in_valid_311,
    output logic             in_ready_311,
    input  logic [WIDTH-1:0] a_311,
    input  logic [WIDTH-1:0] b_311,
    input  logic [OP_W-1:0]  op_311,
    input  logic             acc_clr_311,
    output logic             out_valid_311,
    input  logic             out_ready_311,
    output logic [WIDTH-1:0] y_311,
    output logic             zero_311,
    output logic             parity_311
);
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [OP_W-1:0]  r_s1_op;
    logic [WIDTH-1:0] r_acc;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_parity;
    logic             w_s2_load;
    logic             w_accx_load;
    logic [WIDTH-1:0] w_acc_in;
    logic [WIDTH-1:0] w_y;

    assign w_s2_load     = r_s1_valid & (~r_out_valid | out_ready_311);
    assign w_accx_load   = w_s2_load & (r_s1_op == OP_ACCX);
    assign in_ready_311  = ~rst_311 & (~r_s1_valid | w_s2_load);
    // a same-cycle clear takes effect before the ACCX fold
    assign w_acc_in      = acc_clr_311 ? '0 : r_acc;
    assign out_valid_311 = r_out_valid;
    assign y_311         = r_y;
    assign zero_311      = r_zero;
    assign parity_311    = r_parity;

    logic_op_311 #(.WIDTH(WIDTH)) u_op (
        .i_op  (r_s1_op),
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .i_acc (w_acc_in),
        .o_y   (w_y)
    );

    // stage 1: capture operands whenever the stage is empty or draining into stage 2
    always_ff @(posedge clk_311) begin
        if (rst_311) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
        end else if (in_ready_311) begin
            r_s1_valid <= in_valid_311;
            if (in_valid_311) begin
                r_s1_a  <= a_311;
                r_s1_b  <= b_311;
                r_s1_op <= op_311;
            end
        end
    end

    // stage 2: register result and flags, hold them while the consumer stalls
    always_ff @(posedge clk_311) begin
        if (rst_311) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_zero      <= 1'b0;
            r_parity    <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_y         <= w_y;
            r_zero      <= ~|w_y;
            r_parity    <= ^w_y;
        end else if (out_ready_311) begin
            r_out_valid <= 1'b0;
        end
    end

    // accumulator: folds ACCX operands as they enter stage 2, cleared by level acc_clr
    always_ff @(posedge clk_311) begin
        if (rst_311) r_acc <= '0;
        else if (w_accx_load) r_acc <= w_y;
        else if (acc_clr_311) r_acc <= '0;
    end
endmodule

// File: tb/tb_logic_pipe_311.sv
// tb_logic_pipe_311: scoreboard bench for the gate pipeline at widths 8, 1 and 32
module tb_logic_pipe_311;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        acc_clr = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  op = '0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        in_ready, out_valid, zero, parity;
    logic [7:0]  y;
    logic        x_valid = 1'b0;
    logic [2:0]  x_op = '0;
    logic [31:0] x_a = '0;
    logic [31:0] x_b = '0;
    logic        rdy1, ov1, z1, p1, y1;
    logic        rdy32, ov32, z32, p32;
    logic [31:0] y32;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [9:0]  q[$];
    logic [9:0]  m_exp;
    logic [7:0]  acc_m = '0;
    logic [31:0] acc32_m = '0;
    logic        rand_rdy = 1'b0;

    always #5 clk = ~clk;

    logic_pipe_311 #(.WIDTH(8)) dut (
        .clk_311(clk), .rst_311(rst), .in_valid_311(in_valid), .in_ready_311(in_ready),
        .a_311(a), .b_311(b), .op_311(op), .acc_clr_311(acc_clr),
        .out_valid_311(out_valid), .out_ready_311(out_ready),
        .y_311(y), .zero_311(zero), .parity_311(parity)
    );

    logic_pipe_311 #(.WIDTH(1)) dut1 (
        .clk_311(clk), .rst_311(rst), .in_valid_311(x_valid), .in_ready_311(rdy1),
        .a_311(x_a[0:0]), .b_311(x_b[0:0]), .op_311(x_op), .acc_clr_311(1'b0),
        .out_valid_311(ov1), .out_ready_311(1'b1),
        .y_311(y1), .zero_311(z1), .parity_311(p1)
    );

    logic_pipe_311 #(.WIDTH(32)) dut32 (
        .clk_311(clk), .rst_311(rst), .in_valid_311(x_valid), .in_ready_311(rdy32),
        .a_311(x_a), .b_311(x_b), .op_311(x_op), .acc_clr_311(1'b0),
        .out_valid_311(ov32), .out_ready_311(1'b1),
        .y_311(y32), .zero_311(z32), .parity_311(p32)
    );

    // reference gate rules over 32 bits; narrower widths use the low bits
    function automatic logic [31:0] gate(input logic [2:0] o, input logic [31:0] aa, bb, acc);
        case (o)
            3'd0: return ~aa;
            3'd1: return aa | bb;
            3'd2: return aa & bb;
            3'd3: return ~(aa & bb);
            3'd4: return ~(aa | bb);
            3'd5: return aa ^ bb;
            3'd6: return ~(aa ^ bb);
            default: return acc ^ aa;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, need);
        n_vec++;
        if (got !== need) begin
            n_bad++;
            $display("FAIL %s got %h need %h", name, got, need);
        end
    endtask

    // random consumer back-pressure when enabled
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // monitor: every output transfer is checked against the oldest expected result
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL spurious_out got y=%h need no output", y);
            end else begin
                m_exp = q.pop_front();
                if ({zero, parity, y} !== m_exp) begin
                    n_bad++;
                    $display("FAIL out_zpy got %b/%b/%h need %b/%b/%h",
                             zero, parity, y, m_exp[9], m_exp[8], m_exp[7:0]);
                end
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [7:0] aa, bb);
        int t = 0;
        logic [31:0] r;
        op = o; a = aa; b = bb; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        else begin
            r = gate(o, {24'b0, aa}, {24'b0, bb}, {24'b0, acc_m});
            if (o == 3'd7) acc_m = r[7:0];
            q.push_back({r[7:0] == 8'h00, ^r[7:0], r[7:0]});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic aux(input logic [2:0] o, input logic [31:0] aa, bb);
        logic [31:0] r;
        x_op = o; x_a = aa; x_b = bb; x_valid = 1'b1;
        @(negedge clk);
        chk("w1_in_ready", {31'b0, rdy1}, 1);
        chk("w32_in_ready", {31'b0, rdy32}, 1);
        r = gate(o, aa, bb, acc32_m);
        if (o == 3'd7) acc32_m = r;
        @(posedge clk);
        #1 x_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("w32_y", y32, r);
        chk("w32_v_z_p", {29'b0, ov32, z32, p32}, {29'b0, 1'b1, r == 32'h0, ^r});
        chk("w1_v_z_p_y", {28'b0, ov1, z1, p1, y1}, {28'b0, 1'b1, ~r[0], r[0], r[0]});
    endtask

    initial begin
        logic [7:0] yh;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        rst = 1'b0;
        #1;
        chk("rst_state", {21'b0, out_valid, zero, parity, y}, 0);
        chk("post_rst_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int o = 0; o < 7; o++) send(3'(o), 8'hA5, 8'h3C);
        drain();
        send(3'd5, 8'h77, 8'h77);
        chk("lat_n1_valid", {31'b0, out_valid}, 0);
        @(posedge clk);
        #1;
        chk("lat_n2_valid", {31'b0, out_valid}, 1);
        send(3'd1, 8'h01, 8'h00);
        drain();
        out_ready = 1'b0;
        send(3'd2, 8'hF0, 8'h3C);
        send(3'd3, 8'hAA, 8'h55);
        op = 3'd6; a = 8'h0F; b = 8'h33; in_valid = 1'b1;
        yh = y;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_in_ready", {31'b0, in_ready}, 0);
            chk("stall_valid", {31'b0, out_valid}, 1);
            chk("stall_y_hold", {24'b0, y}, {24'b0, yh});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(3'd6, 8'h0F, 8'h33);
        drain();
        send(3'd7, 8'h0F, 8'h00);
        send(3'd7, 8'hF0, 8'h00);
        send(3'd7, 8'hFF, 8'h00);
        send(3'd7, 8'h3C, 8'h00);
        acc_m = 8'h00;
        send(3'd7, 8'h12, 8'h00);
        acc_clr = 1'b1;
        @(posedge clk);
        #1 acc_clr = 1'b0;
        send(3'd7, 8'h01, 8'h00);
        drain();
        acc_clr = 1'b1;
        @(posedge clk);
        #1 acc_clr = 1'b0;
        acc_m = 8'h00;
        send(3'd7, 8'h0A, 8'h00);
        send(3'd0, 8'h11, 8'h00);
        send(3'd0, 8'h22, 8'h00);
        rst = 1'b1;
        q.delete();
        acc_m = 8'h00;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_y", {24'b0, y}, 0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        send(3'd7, 8'h05, 8'h00);
        drain();
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i % 60 == 59) begin
                drain();
                acc_clr = 1'b1;
                @(posedge clk);
                #1 acc_clr = 1'b0;
                acc_m = 8'h00;
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int o = 0; o < 8; o++)
            for (int p = 0; p < 4; p++)
                aux(3'(o), p[1] ? 32'hFFFF_FFFF : 32'h0, p[0] ? 32'hFFFF_FFFF : 32'h0);
        repeat (2) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
